// File: rtl/mac_tx_retry.sv
// mac_tx_retry: half-duplex CSMA/CD retry controller between the TX replay
// buffer and the MAC/PHY encoder.
//
// Frame bytes pass straight through while sending. An effective collision
// (half_duplex high) stops the frame, emits a jam sequence and then either
// asks the replay buffer to rewind and waits a truncated binary exponential
// backoff, or aborts the frame (late or excessive collision) and drains the
// rest of it from the buffer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_axis_*            frame stream from the replay buffer
//   m_axis_*            stream to the encoder; m_axis_err marks an aborted frame
//   replay              one-cycle pulse: rewind the replay buffer
//   done                one-cycle pulse: frame finished (sent or aborted)
//   replayable          replay buffer still holds the frame start
//   half_duplex         collisions are honoured only when high
//   collision           collision detect
//   tx_abort            one-cycle pulse when an aborted frame has been drained
//   coll_count          collisions seen in the current frame, saturating at 16
module mac_tx_retry #(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned SLOT_CYCLES = 64,
    parameter int unsigned JAM_CYCLES = 4,
    parameter logic [DATA_WIDTH-1:0] JAM_DATA = 9'h055,
    parameter int unsigned MAX_ATTEMPTS = 16,
    parameter int unsigned BACKOFF_LIMIT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic                  m_axis_err,
    output logic                  replay,
    output logic                  done,
    input  logic                  replayable,
    input  logic                  half_duplex,
    input  logic                  collision,
    output logic                  tx_abort,
    output logic [4:0]            coll_count
);

    localparam int unsigned CntW = $clog2(((1 << BACKOFF_LIMIT) - 1) * SLOT_CYCLES + 2);
    localparam int unsigned JamW = $clog2(JAM_CYCLES + 1);
    localparam int unsigned AttW = $clog2(MAX_ATTEMPTS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StJam,
        StBackoff,
        StDrain,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [AttW-1:0]     attempt_q, attempt_d;
    logic [4:0]          coll_q, coll_d;
    logic                abort_q, abort_d;
    logic [JamW-1:0]     jam_cnt_q, jam_cnt_d;
    logic [CntW-1:0]     bo_cnt_q, bo_cnt_d;
    logic [15:0]         lfsr_q, lfsr_d;

    logic                eff_coll;
    logic                excess;
    logic                jam_final;
    logic [31:0]         exp_w;
    logic [9:0]          bo_mask;
    logic [9:0]          bo_k;
    logic [CntW-1:0]     bo_wait;

    assign coll_count = coll_q;

    assign eff_coll  = (state_q == StSend) && half_duplex && collision;
    // The collision being handled now is the one that uses up the last attempt.
    assign excess    = (32'(attempt_q) + 32'd1) >= MAX_ATTEMPTS;
    assign jam_final = (jam_cnt_q == JamW'(JAM_CYCLES - 1));

    // Backoff slot count, evaluated as the jam ends; attempt_q already
    // includes the collision that caused this backoff.
    assign exp_w = (32'(attempt_q) > BACKOFF_LIMIT) ? BACKOFF_LIMIT : 32'(attempt_q);

    always_comb begin
        bo_mask = '0;
        for (int i = 0; i < 10; i++) begin
            bo_mask[i] = (32'(i) < exp_w);
        end
    end

    assign bo_k    = lfsr_q[9:0] & bo_mask;
    // k = 0 still spends one cycle in backoff.
    assign bo_wait = (bo_k == 10'd0) ? CntW'(1) : CntW'(bo_k) * CntW'(SLOT_CYCLES);

    // Output decode.
    always_comb begin
        s_axis_ready = 1'b0;
        m_axis_data  = '0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        m_axis_err   = 1'b0;
        replay       = 1'b0;
        done         = 1'b0;
        tx_abort     = 1'b0;
        case (state_q)
            StSend: begin
                if (eff_coll) begin
                    // Suppress the handshake; the byte is resent or drained.
                    replay = replayable && !excess;
                end else begin
                    m_axis_data  = s_axis_data;
                    m_axis_valid = s_axis_valid;
                    m_axis_last  = s_axis_last;
                    s_axis_ready = m_axis_ready;
                end
            end
            StJam: begin
                m_axis_data  = JAM_DATA;
                m_axis_valid = 1'b1;
                m_axis_last  = jam_final;
                m_axis_err   = jam_final && abort_q;
            end
            StDrain: begin
                s_axis_ready = 1'b1;
                if (s_axis_valid && s_axis_last) begin
                    tx_abort = 1'b1;
                    done     = 1'b1;
                end
            end
            StDone: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        attempt_d = attempt_q;
        coll_d    = coll_q;
        abort_d   = abort_q;
        jam_cnt_d = jam_cnt_q;
        bo_cnt_d  = bo_cnt_q;
        // Fibonacci LFSR, taps 16,14,13,11.
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        case (state_q)
            StIdle: begin
                if (s_axis_valid) begin
                    state_d   = StSend;
                    attempt_d = '0;
                    coll_d    = '0;
                    abort_d   = 1'b0;
                end
            end
            StSend: begin
                if (eff_coll) begin
                    attempt_d = attempt_q + AttW'(1);
                    if (coll_q != 5'd16) begin
                        coll_d = coll_q + 5'd1;
                    end
                    abort_d   = excess || !replayable;
                    jam_cnt_d = '0;
                    state_d   = StJam;
                end else if (s_axis_valid && m_axis_ready && s_axis_last) begin
                    state_d = StDone;
                end
            end
            StJam: begin
                // Jam words advance on handshakes only.
                if (m_axis_ready) begin
                    if (jam_final) begin
                        state_d  = abort_q ? StDrain : StBackoff;
                        bo_cnt_d = bo_wait;
                    end else begin
                        jam_cnt_d = jam_cnt_q + JamW'(1);
                    end
                end
            end
            StBackoff: begin
                if (bo_cnt_q <= CntW'(1)) begin
                    state_d = StSend;
                end else begin
                    bo_cnt_d = bo_cnt_q - CntW'(1);
                end
            end
            StDrain: begin
                if (s_axis_valid && s_axis_last) begin
                    state_d   = StIdle;
                    attempt_d = '0;
                    abort_d   = 1'b0;
                end
            end
            StDone: begin
                state_d   = StIdle;
                attempt_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            attempt_q <= '0;
            coll_q    <= '0;
            abort_q   <= 1'b0;
            jam_cnt_q <= '0;
            bo_cnt_q  <= '0;
            lfsr_q    <= 16'hACE1;
        end else begin
            state_q   <= state_d;
            attempt_q <= attempt_d;
            coll_q    <= coll_d;
            abort_q   <= abort_d;
            jam_cnt_q <= jam_cnt_d;
            bo_cnt_q  <= bo_cnt_d;
            lfsr_q    <= lfsr_d;
        end
    end

endmodule

// File: tb/tb_mac_tx_retry.sv
// Directed bench for mac_tx_retry. A small replay-buffer model feeds frames
// whose words are {1'b1, index}, so they can never be confused with the jam
// word. The slot time is shortened to keep the excessive-collision run short.
module tb_mac_tx_retry;

    localparam int unsigned DW   = 9;
    localparam int unsigned SLOT = 8;
    localparam logic [DW-1:0] JAM = 9'h055;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_data;
    logic          s_axis_valid;
    logic          s_axis_ready;
    logic          s_axis_last;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic          m_axis_last;
    logic          m_axis_err;
    logic          replay;
    logic          done;
    logic          replayable;
    logic          half_duplex;
    logic          collision;
    logic          tx_abort;
    logic [4:0]    coll_count;

    mac_tx_retry #(
        .DATA_WIDTH   (DW),
        .SLOT_CYCLES  (SLOT),
        .JAM_CYCLES   (4),
        .JAM_DATA     (JAM),
        .MAX_ATTEMPTS (16),
        .BACKOFF_LIMIT(10)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis_data (s_axis_data),
        .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready),
        .s_axis_last (s_axis_last),
        .m_axis_data (m_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .m_axis_last (m_axis_last),
        .m_axis_err  (m_axis_err),
        .replay      (replay),
        .done        (done),
        .replayable  (replayable),
        .half_duplex (half_duplex),
        .collision   (collision),
        .tx_abort    (tx_abort),
        .coll_count  (coll_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-frame observations.
    int  n_data, last_idx, data_bad, err_bad;
    int  jam_words, jam_last_cnt, jam_last_pos, jam_err_cnt;
    int  replay_cnt, replay_on_coll, done_cnt, done_cyc, both_cnt;
    int  abort_cnt, abort_cyc, abort_on_last, last_hs_cyc, jam_end_cyc;
    bit  in_bo, done_seen;
    int  bo_q[$];

    task automatic drive_idle();
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        s_axis_last  = 1'b0;
        m_axis_ready = 1'b1;
        collision    = 1'b0;
        half_duplex  = 1'b1;
        replayable   = 1'b1;
    endtask

    // coll_at < 0: no pulsed collision. hold: collision high all frame.
    // bp: periodic m_axis_ready backpressure. rst_bo: assert rst in backoff.
    task automatic run_frame(input int len, input int coll_at, input bit hd, input bit rpl,
                             input bit hold, input bit bp, input bit rst_bo, input int max_cyc);
        int sidx;
        bit pend;
        int tail;
        n_data = 0; last_idx = -1; data_bad = 0; err_bad = 0;
        jam_words = 0; jam_last_cnt = 0; jam_last_pos = 0; jam_err_cnt = 0;
        replay_cnt = 0; replay_on_coll = 0; done_cnt = 0; done_cyc = -1; both_cnt = 0;
        abort_cnt = 0; abort_cyc = -2; abort_on_last = 0; last_hs_cyc = -5; jam_end_cyc = 0;
        in_bo = 1'b0; done_seen = 1'b0;
        bo_q.delete();
        sidx = 0;
        pend = (coll_at >= 0);
        tail = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            s_axis_valid = (sidx < len);
            s_axis_data  = {1'b1, 8'(sidx)};
            s_axis_last  = (sidx == len - 1);
            m_axis_ready = bp ? ((c % 3) != 1) : 1'b1;
            half_duplex  = hd;
            replayable   = rpl;
            collision    = hold || (pend && sidx == coll_at);
            if (rst_bo && in_bo && c == jam_end_cyc + 1) begin
                rst = 1'b1;
                break;
            end
            #1;
            if (replay) begin
                replay_cnt++;
                if (collision && sidx == coll_at) replay_on_coll++;
            end
            if (collision && !hold) pend = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc  = c;
                done_seen = 1'b1;
                if (replay) both_cnt++;
            end
            if (tx_abort) begin
                abort_cnt++;
                abort_cyc = c;
                if (s_axis_valid && s_axis_ready && s_axis_last) abort_on_last++;
            end
            if (m_axis_valid) begin
                if (m_axis_data == JAM) begin
                    // Next jam after backoff: one SEND cycle precedes it.
                    if (in_bo && c > jam_end_cyc) begin
                        bo_q.push_back(c - jam_end_cyc - 2);
                        in_bo = 1'b0;
                    end
                    if (m_axis_ready) begin
                        jam_words++;
                        if (m_axis_last) begin
                            jam_last_cnt++;
                            jam_last_pos = jam_words;
                            if (m_axis_err) jam_err_cnt++;
                            jam_end_cyc = c;
                            in_bo = 1'b1;
                        end
                    end
                end else begin
                    if (in_bo) begin
                        bo_q.push_back(c - jam_end_cyc - 1);
                        in_bo = 1'b0;
                    end
                    if (m_axis_ready) begin
                        if (m_axis_data != {1'b1, 8'(n_data)}) data_bad++;
                        if (m_axis_err) err_bad++;
                        if (m_axis_last) begin
                            last_idx    = n_data;
                            last_hs_cyc = c;
                        end
                        n_data++;
                    end
                end
            end
            if (s_axis_valid && s_axis_ready) sidx++;
            if (replay) begin
                sidx     = 0;
                n_data   = 0;
                last_idx = -1;
            end
            if (tail > 0) begin
                tail--;
                if (tail == 0) break;
            end else if (done_seen && tail < 0) begin
                tail = 2;
            end
        end
    endtask

    task automatic check_clean(input string tag);
        check_eq({tag, "_done_seen"}, 32'(done_seen), 1);
        check_eq({tag, "_n_data"}, n_data, 60);
        check_eq({tag, "_data_bad"}, data_bad, 0);
        check_eq({tag, "_last_idx"}, last_idx, 59);
        check_eq({tag, "_done_lat"}, done_cyc - last_hs_cyc, 1);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_replay_cnt"}, replay_cnt, 0);
        check_eq({tag, "_jam_words"}, jam_words, 0);
        check_eq({tag, "_abort_cnt"}, abort_cnt, 0);
        check_eq({tag, "_err_bad"}, err_bad, 0);
        check_eq({tag, "_coll_count"}, 32'(coll_count), 0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_s_ready"}, 32'(s_axis_ready), 0);
        check_eq({tag, "_m_valid"}, 32'(m_axis_valid), 0);
        check_eq({tag, "_m_last"}, 32'(m_axis_last), 0);
        check_eq({tag, "_m_err"}, 32'(m_axis_err), 0);
        check_eq({tag, "_replay"}, 32'(replay), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_tx_abort"}, 32'(tx_abort), 0);
        check_eq({tag, "_coll_count"}, 32'(coll_count), 0);
    endtask

    initial begin
        int bo_bad;
        int lim;
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b0;

        // Clean 60-byte frame.
        run_frame(60, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 500);
        #1;
        check_clean("clean");

        // Collision at byte 10, replayable, with backpressure.
        run_frame(60, 9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1000);
        #1;
        check_eq("c10_done_seen", 32'(done_seen), 1);
        check_eq("c10_replay_cnt", replay_cnt, 1);
        check_eq("c10_replay_on_coll", replay_on_coll, 1);
        check_eq("c10_jam_words", jam_words, 4);
        check_eq("c10_jam_last_pos", jam_last_pos, 4);
        check_eq("c10_jam_err", jam_err_cnt, 0);
        check_eq("c10_bo_n", bo_q.size(), 1);
        if (bo_q.size() == 1) begin
            check_eq("c10_bo_len", 32'((bo_q[0] == 1) || (bo_q[0] == SLOT)), 1);
        end
        check_eq("c10_n_data", n_data, 60);
        check_eq("c10_data_bad", data_bad, 0);
        check_eq("c10_last_idx", last_idx, 59);
        check_eq("c10_done_lat", done_cyc - last_hs_cyc, 1);
        check_eq("c10_done_cnt", done_cnt, 1);
        check_eq("c10_coll_count", 32'(coll_count), 1);

        // Late collision at byte 58.
        run_frame(60, 57, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 500);
        #1;
        check_eq("late_done_seen", 32'(done_seen), 1);
        check_eq("late_replay_cnt", replay_cnt, 0);
        check_eq("late_jam_words", jam_words, 4);
        check_eq("late_jam_last_pos", jam_last_pos, 4);
        check_eq("late_jam_err", jam_err_cnt, 1);
        check_eq("late_n_data", n_data, 57);
        check_eq("late_last_idx", last_idx, -1);
        check_eq("late_abort_cnt", abort_cnt, 1);
        check_eq("late_abort_on_last", abort_on_last, 1);
        check_eq("late_abort_with_done", abort_cyc, done_cyc);
        check_eq("late_done_cnt", done_cnt, 1);
        check_eq("late_bo_n", bo_q.size(), 0);
        check_eq("late_coll_count", 32'(coll_count), 1);

        // Collision on every attempt -> excessive-collision abort.
        run_frame(4, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 90000);
        #1;
        check_eq("exc_done_seen", 32'(done_seen), 1);
        check_eq("exc_replay_cnt", replay_cnt, 15);
        check_eq("exc_jam_last_cnt", jam_last_cnt, 16);
        check_eq("exc_jam_err", jam_err_cnt, 1);
        check_eq("exc_bo_n", bo_q.size(), 15);
        bo_bad = 0;
        foreach (bo_q[i]) begin
            lim = ((1 << ((i + 1) > 10 ? 10 : (i + 1))) - 1) * SLOT;
            if (bo_q[i] < 1 || bo_q[i] > lim) bo_bad++;
        end
        check_eq("exc_bo_bound", bo_bad, 0);
        check_eq("exc_abort_cnt", abort_cnt, 1);
        check_eq("exc_abort_on_last", abort_on_last, 1);
        check_eq("exc_done_cnt", done_cnt, 1);
        check_eq("exc_both", both_cnt, 0);
        check_eq("exc_n_data", n_data, 0);
        check_eq("exc_coll_count", 32'(coll_count), 16);

        // Full duplex: collision held high is ignored.
        run_frame(60, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 500);
        #1;
        check_clean("fdx");

        // Reset during backoff, then a clean frame.
        run_frame(60, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 500);
        check_eq("rstbo_replay_cnt", replay_cnt, 1);
        check_eq("rstbo_in_backoff", 32'(in_bo), 1);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        #1;
        check_quiet("rstbo");
        run_frame(60, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 500);
        #1;
        check_clean("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
